mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, sitting between the EXE/MEM register and the WB stage.
- Decodes load/store size and alignment and runs the data-bus request/ack transaction.
- Formats store byte lanes: byte-swapped for RAM, unswapped for device space.
- Registers everything the WB stage consumes: write-back controls, raw bus read data, read byte-enable, unsigned flag, device flag, HI/LO, CP0 write and PC.
- Raises AdEL/AdES address exceptions toward CP0.

---
 rtl/mem_access_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: load/store lane decode, data-bus handshake, WB registers
// Non-memory ops pass to WB in one cycle; aligned loads/stores hold in BUS until dbus_ack.
module mem_access_stage #(
  parameter logic [31:0] DEV_BASE = 32'hBFAF_0000,
  parameter logic [31:0] DEV_MASK = 32'hFFFF_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush_i,
  input  logic        mem_load_i,
  input  logic        mem_store_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsign_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic [4:0]  mem_wa_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_dreg_i,
  input  logic        mem_whilo_i,
  input  logic [63:0] mem_dhilo_i,
  input  logic        mem_cp0_we_i,
  input  logic [4:0]  mem_cp0_waddr_i,
  input  logic [31:0] mem_cp0_wdata_i,
  input  logic [31:0] mem_pc_i,
  output logic        dbus_req,
  output logic [3:0]  dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid_o,
  output logic [4:0]  wb_wa_o,
  output logic        wb_wreg_o,
  output logic        wb_mreg_o,
  output logic [31:0] wb_dreg_o,
  output logic [3:0]  wb_dre_o,
  output logic        wb_unsign_o,
  output logic        wb_device_o,
  output logic [31:0] wb_dm_o,
  output logic        wb_whilo_o,
  output logic [63:0] wb_dhilo_o,
  output logic        wb_cp0_we_o,
  output logic [4:0]  wb_cp0_waddr_o,
  output logic [31:0] wb_cp0_wdata_o,
  output logic [31:0] wb_pc_o,
  output logic        exc_valid_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_badvaddr_o
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t state, state_next;
  logic is_mem, is_half, is_word, misalign, in_device;
  logic accept, start_bus;
  logic [3:0]  lanes;
  logic [31:0] sdata_fmt;
  logic kill;

  logic [29:0] cap_addr;
  logic [3:0]  cap_we, cap_lanes;
  logic [31:0] cap_wdata, cap_dreg, cap_cp0_wdata, cap_pc;
  logic        cap_load, cap_unsign, cap_device, cap_wreg, cap_whilo, cap_cp0_we;
  logic [4:0]  cap_wa, cap_cp0_waddr;
  logic [63:0] cap_dhilo;

  // Bus lanes are big-endian: byte address 0 lives in dbus bits [31:24].
  always_comb begin
    is_mem    = mem_load_i | mem_store_i;
    is_word   = mem_size_i[1];
    is_half   = (mem_size_i == 2'b01);
    misalign  = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
    in_device = ((mem_addr_i & DEV_MASK) == DEV_BASE);
    if (is_word) begin
      lanes     = 4'b1111;
      sdata_fmt = in_device ? mem_sdata_i
                            : {mem_sdata_i[7:0], mem_sdata_i[15:8], mem_sdata_i[23:16], mem_sdata_i[31:24]};
    end else if (is_half) begin
      lanes     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      sdata_fmt = {2{mem_sdata_i[7:0], mem_sdata_i[15:8]}};
    end else begin
      lanes     = 4'b1000 >> mem_addr_i[1:0];
      sdata_fmt = {4{mem_sdata_i[7:0]}};
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    start_bus  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush_i) begin
          accept = 1'b1;
          if (is_mem && !misalign) begin
            start_bus  = 1'b1;
            state_next = BUS;
          end
        end
      end
      BUS: if (dbus_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_next;
  end

  assign in_ready   = (state == IDLE);
  assign dbus_req   = (state == BUS);
  assign dbus_we    = (state == BUS) ? cap_we : 4'b0000;
  assign dbus_addr  = {cap_addr, 2'b00};
  assign dbus_wdata = cap_wdata;

  always_ff @(posedge cpu_clk) begin
    if (start_bus) begin
      cap_addr      <= mem_addr_i[31:2];
      cap_we        <= mem_store_i ? lanes : 4'b0000;
      cap_lanes     <= lanes;
      cap_wdata     <= sdata_fmt;
      cap_load      <= mem_load_i;
      cap_unsign    <= mem_unsign_i;
      cap_device    <= in_device;
      cap_wa        <= mem_wa_i;
      cap_wreg      <= mem_wreg_i;
      cap_dreg      <= mem_dreg_i;
      cap_whilo     <= mem_whilo_i;
      cap_dhilo     <= mem_dhilo_i;
      cap_cp0_we    <= mem_cp0_we_i;
      cap_cp0_waddr <= mem_cp0_waddr_i;
      cap_cp0_wdata <= mem_cp0_wdata_i;
      cap_pc        <= mem_pc_i;
    end
  end

  // Bubble by default: clear every write enable; data fields keep their last value.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      kill           <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_wa_o        <= 5'd0;
      wb_wreg_o      <= 1'b0;
      wb_mreg_o      <= 1'b0;
      wb_dreg_o      <= 32'd0;
      wb_dre_o       <= 4'd0;
      wb_unsign_o    <= 1'b0;
      wb_device_o    <= 1'b0;
      wb_dm_o        <= 32'd0;
      wb_whilo_o     <= 1'b0;
      wb_dhilo_o     <= 64'd0;
      wb_cp0_we_o    <= 1'b0;
      wb_cp0_waddr_o <= 5'd0;
      wb_cp0_wdata_o <= 32'd0;
      wb_pc_o        <= 32'hBFC0_0000;
      exc_valid_o    <= 1'b0;
      exc_code_o     <= 5'd0;
      exc_badvaddr_o <= 32'd0;
    end else begin
      wb_valid_o  <= 1'b0;
      wb_wreg_o   <= 1'b0;
      wb_mreg_o   <= 1'b0;
      wb_whilo_o  <= 1'b0;
      wb_cp0_we_o <= 1'b0;
      exc_valid_o <= 1'b0;
      if (state == IDLE) begin
        kill <= 1'b0;
        if (accept && is_mem && misalign) begin
          exc_valid_o    <= 1'b1;
          exc_code_o     <= mem_load_i ? 5'd4 : 5'd5;
          exc_badvaddr_o <= mem_addr_i;
        end else if (accept && !is_mem) begin
          wb_valid_o     <= 1'b1;
          wb_wa_o        <= mem_wa_i;
          wb_wreg_o      <= mem_wreg_i;
          wb_dreg_o      <= mem_dreg_i;
          wb_dre_o       <= 4'b0000;
          wb_unsign_o    <= mem_unsign_i;
          wb_device_o    <= 1'b0;
          wb_whilo_o     <= mem_whilo_i;
          wb_dhilo_o     <= mem_dhilo_i;
          wb_cp0_we_o    <= mem_cp0_we_i;
          wb_cp0_waddr_o <= mem_cp0_waddr_i;
          wb_cp0_wdata_o <= mem_cp0_wdata_i;
          wb_pc_o        <= mem_pc_i;
        end
      end else begin
        if (flush_i) kill <= 1'b1;
        if (dbus_ack) begin
          kill    <= 1'b0;
          wb_dm_o <= dbus_rdata;
          if (!kill && !flush_i) begin
            wb_valid_o     <= 1'b1;
            wb_wa_o        <= cap_wa;
            wb_wreg_o      <= cap_wreg;
            wb_mreg_o      <= cap_load;
            wb_dreg_o      <= cap_dreg;
            wb_dre_o       <= cap_load ? cap_lanes : 4'b0000;
            wb_unsign_o    <= cap_unsign;
            wb_device_o    <= cap_device;
            wb_whilo_o     <= cap_whilo;
            wb_dhilo_o     <= cap_dhilo;
            wb_cp0_we_o    <= cap_cp0_we;
            wb_cp0_waddr_o <= cap_cp0_waddr;
            wb_cp0_wdata_o <= cap_cp0_wdata;
            wb_pc_o        <= cap_pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench for mem_access_stage
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_access_stage;

  logic        cpu_clk, cpu_rst, in_valid, in_ready, flush_i;
  logic        mem_load_i, mem_store_i, mem_unsign_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_sdata_i, mem_dreg_i, mem_cp0_wdata_i, mem_pc_i;
  logic [4:0]  mem_wa_i, mem_cp0_waddr_i;
  logic        mem_wreg_i, mem_whilo_i, mem_cp0_we_i;
  logic [63:0] mem_dhilo_i;
  logic        dbus_req, dbus_ack;
  logic [3:0]  dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic        wb_valid_o, wb_wreg_o, wb_mreg_o, wb_unsign_o, wb_device_o, wb_whilo_o, wb_cp0_we_o;
  logic [4:0]  wb_wa_o, wb_cp0_waddr_o, exc_code_o;
  logic [31:0] wb_dreg_o, wb_dm_o, wb_cp0_wdata_o, wb_pc_o, exc_badvaddr_o;
  logic [3:0]  wb_dre_o;
  logic [63:0] wb_dhilo_o;
  logic        exc_valid_o;

  int passed = 0;
  int total  = 0;

  mem_access_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .in_valid(in_valid), .in_ready(in_ready), .flush_i(flush_i),
    .mem_load_i(mem_load_i), .mem_store_i(mem_store_i), .mem_size_i(mem_size_i), .mem_unsign_i(mem_unsign_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .mem_wa_i(mem_wa_i), .mem_wreg_i(mem_wreg_i),
    .mem_dreg_i(mem_dreg_i), .mem_whilo_i(mem_whilo_i), .mem_dhilo_i(mem_dhilo_i),
    .mem_cp0_we_i(mem_cp0_we_i), .mem_cp0_waddr_i(mem_cp0_waddr_i), .mem_cp0_wdata_i(mem_cp0_wdata_i),
    .mem_pc_i(mem_pc_i), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_valid_o(wb_valid_o), .wb_wa_o(wb_wa_o), .wb_wreg_o(wb_wreg_o), .wb_mreg_o(wb_mreg_o),
    .wb_dreg_o(wb_dreg_o), .wb_dre_o(wb_dre_o), .wb_unsign_o(wb_unsign_o), .wb_device_o(wb_device_o),
    .wb_dm_o(wb_dm_o), .wb_whilo_o(wb_whilo_o), .wb_dhilo_o(wb_dhilo_o), .wb_cp0_we_o(wb_cp0_we_o),
    .wb_cp0_waddr_o(wb_cp0_waddr_o), .wb_cp0_wdata_o(wb_cp0_wdata_o), .wb_pc_o(wb_pc_o),
    .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .exc_badvaddr_o(exc_badvaddr_o)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; flush_i = 0; mem_load_i = 0; mem_store_i = 0; mem_size_i = 2'b10;
    mem_unsign_i = 0; mem_addr_i = 0; mem_sdata_i = 0; mem_wa_i = 0; mem_wreg_i = 0;
    mem_dreg_i = 0; mem_whilo_i = 0; mem_dhilo_i = 0; mem_cp0_we_i = 0; mem_cp0_waddr_i = 0;
    mem_cp0_wdata_i = 0; mem_pc_i = 0; dbus_ack = 0; dbus_rdata = 0;
  endtask

  task automatic test_reset();
    clear_in();
    cpu_rst = 1;
    tick(); tick();
    cpu_rst = 0;
    total++;
    if ({dbus_req, dbus_we, in_ready} !== {1'b0, 4'b0000, 1'b1})
      $display("FAIL reset_bus req/we/ready got %b/%b/%b exp 0/0000/1", dbus_req, dbus_we, in_ready);
    else passed++;
    total++;
    if ({wb_valid_o, wb_wreg_o, wb_mreg_o, wb_dre_o, wb_dm_o, exc_valid_o, exc_code_o} !== 44'd0)
      $display("FAIL reset_wb nonzero wb/exc outputs valid=%b wreg=%b dm=%h exc=%b", wb_valid_o, wb_wreg_o, wb_dm_o, exc_valid_o);
    else passed++;
    total++;
    if (wb_pc_o !== 32'hBFC0_0000) $display("FAIL reset_pc got %h exp bfc00000", wb_pc_o);
    else passed++;
  endtask

  task automatic test_load_word();
    clear_in();
    in_valid = 1; mem_load_i = 1; mem_size_i = 2'b10; mem_addr_i = 32'h0000_1000;
    mem_wa_i = 5'd5; mem_wreg_i = 1; mem_pc_i = 32'h0000_0100;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({dbus_req, in_ready, dbus_we} !== {1'b1, 1'b0, 4'b0000})
        $display("FAIL lw_bus cyc%0d req/ready/we got %b/%b/%b exp 1/0/0000", i, dbus_req, in_ready, dbus_we);
      else passed++;
      total++;
      if ({dbus_addr, wb_valid_o} !== {32'h0000_1000, 1'b0})
        $display("FAIL lw_addr cyc%0d addr=%h wb_valid=%b exp 00001000/0", i, dbus_addr, wb_valid_o);
      else passed++;
      if (i == 2) begin dbus_ack = 1; dbus_rdata = 32'h1122_3344; end
      tick();
    end
    dbus_ack = 0; dbus_rdata = 0;
    total++;
    if ({dbus_req, in_ready, wb_valid_o} !== 3'b011)
      $display("FAIL lw_done req/ready/valid got %b/%b/%b exp 0/1/1", dbus_req, in_ready, wb_valid_o);
    else passed++;
    total++;
    if ({wb_dre_o, wb_dm_o, wb_mreg_o, wb_device_o, wb_wreg_o, wb_wa_o} !== {4'b1111, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 5'd5})
      $display("FAIL lw_wb dre=%b dm=%h mreg=%b dev=%b wreg=%b wa=%0d exp 1111/11223344/1/0/1/5",
               wb_dre_o, wb_dm_o, wb_mreg_o, wb_device_o, wb_wreg_o, wb_wa_o);
    else passed++;
    total++;
    if (wb_pc_o !== 32'h0000_0100) $display("FAIL lw_pc got %h exp 00000100", wb_pc_o);
    else passed++;
    tick();
    total++;
    if ({wb_valid_o, wb_wreg_o} !== 2'b00) $display("FAIL lw_once valid/wreg got %b/%b exp 0/0", wb_valid_o, wb_wreg_o);
    else passed++;
  endtask

  task automatic test_store();
    logic [1:0]  sz   [4];
    logic [31:0] addr [4];
    logic [31:0] dat  [4];
    logic [3:0]  ewe  [4];
    logic [31:0] ewd  [4];
    logic [31:0] ewa  [4];
    logic        edev [4];
    sz[0] = 2'b00; addr[0] = 32'h0000_1003; dat[0] = 32'h0000_00AB; ewe[0] = 4'b0001; ewd[0] = 32'hABAB_ABAB; ewa[0] = 32'h0000_1000; edev[0] = 0;
    sz[1] = 2'b01; addr[1] = 32'h0000_1002; dat[1] = 32'h0000_1234; ewe[1] = 4'b0011; ewd[1] = 32'h3412_3412; ewa[1] = 32'h0000_1000; edev[1] = 0;
    sz[2] = 2'b10; addr[2] = 32'hBFAF_F000; dat[2] = 32'hDEAD_BEEF; ewe[2] = 4'b1111; ewd[2] = 32'hDEAD_BEEF; ewa[2] = 32'hBFAF_F000; edev[2] = 1;
    sz[3] = 2'b10; addr[3] = 32'h0000_2000; dat[3] = 32'hDEAD_BEEF; ewe[3] = 4'b1111; ewd[3] = 32'hEFBE_ADDE; ewa[3] = 32'h0000_2000; edev[3] = 0;
    for (int i = 0; i < 4; i++) begin
      clear_in();
      in_valid = 1; mem_store_i = 1; mem_size_i = sz[i]; mem_addr_i = addr[i]; mem_sdata_i = dat[i];
      mem_pc_i = 32'h0000_0200 + 32'(i * 4);
      tick();
      in_valid = 0;
      total++;
      if ({dbus_req, dbus_we, dbus_wdata, dbus_addr} !== {1'b1, ewe[i], ewd[i], ewa[i]})
        $display("FAIL store%0d req=%b we=%b wdata=%h addr=%h exp 1/%b/%h/%h",
                 i, dbus_req, dbus_we, dbus_wdata, dbus_addr, ewe[i], ewd[i], ewa[i]);
      else passed++;
      dbus_ack = 1;
      tick();
      dbus_ack = 0;
      total++;
      if ({dbus_req, wb_valid_o, wb_mreg_o, wb_wreg_o, wb_dre_o, wb_device_o} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, edev[i]})
        $display("FAIL store%0d_wb req=%b valid=%b mreg=%b wreg=%b dre=%b dev=%b exp 0/1/0/0/0000/%b",
                 i, dbus_req, wb_valid_o, wb_mreg_o, wb_wreg_o, wb_dre_o, wb_device_o, edev[i]);
      else passed++;
    end
  endtask

  task automatic test_misalign();
    clear_in();
    in_valid = 1; mem_load_i = 1; mem_size_i = 2'b01; mem_addr_i = 32'h0000_1001; mem_wreg_i = 1; mem_wa_i = 5'd9;
    tick();
    in_valid = 0;
    total++;
    if ({dbus_req, in_ready, exc_valid_o, exc_code_o, exc_badvaddr_o} !== {1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_1001})
      $display("FAIL adel req=%b ready=%b exc=%b code=%0d bad=%h exp 0/1/1/4/00001001",
               dbus_req, in_ready, exc_valid_o, exc_code_o, exc_badvaddr_o);
    else passed++;
    total++;
    if ({wb_wreg_o, wb_valid_o} !== 2'b00) $display("FAIL adel_bubble wreg/valid got %b/%b exp 0/0", wb_wreg_o, wb_valid_o);
    else passed++;
    clear_in();
    in_valid = 1; mem_store_i = 1; mem_size_i = 2'b10; mem_addr_i = 32'h0000_1002;
    tick();
    in_valid = 0;
    total++;
    if ({dbus_req, exc_valid_o, exc_code_o, exc_badvaddr_o} !== {1'b0, 1'b1, 5'd5, 32'h0000_1002})
      $display("FAIL ades req=%b exc=%b code=%0d bad=%h exp 0/1/5/00001002", dbus_req, exc_valid_o, exc_code_o, exc_badvaddr_o);
    else passed++;
    tick();
    total++;
    if (exc_valid_o !== 1'b0) $display("FAIL exc_once got %b exp 0", exc_valid_o);
    else passed++;
  endtask

  task automatic test_flush();
    clear_in();
    in_valid = 1; mem_load_i = 1; mem_size_i = 2'b10; mem_addr_i = 32'h0000_3000; mem_wreg_i = 1; mem_wa_i = 5'd7;
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      flush_i  = (i == 1);
      dbus_ack = (i == 3);
      dbus_rdata = 32'h5566_7788;
      total++;
      if (dbus_req !== 1'b1) $display("FAIL flush_req cyc%0d got %b exp 1", i, dbus_req);
      else passed++;
      tick();
    end
    clear_in();
    total++;
    if ({dbus_req, in_ready, wb_valid_o, wb_wreg_o, wb_mreg_o} !== 5'b01000)
      $display("FAIL flush_bubble req=%b ready=%b valid=%b wreg=%b mreg=%b exp 0/1/0/0/0",
               dbus_req, in_ready, wb_valid_o, wb_wreg_o, wb_mreg_o);
    else passed++;
    in_valid = 1; flush_i = 1; mem_wreg_i = 1; mem_pc_i = 32'h0000_0300;
    tick();
    clear_in();
    total++;
    if ({dbus_req, wb_valid_o, wb_wreg_o} !== 3'b000)
      $display("FAIL idle_flush req=%b valid=%b wreg=%b exp 0/0/0", dbus_req, wb_valid_o, wb_wreg_o);
    else passed++;
    in_valid = 1; mem_load_i = 1; mem_size_i = 2'b00; mem_addr_i = 32'h0000_3001;
    tick();
    clear_in();
    total++;
    if ({dbus_req, dbus_we} !== 5'b1_0000) $display("FAIL rst_pre req=%b we=%b exp 1/0000", dbus_req, dbus_we);
    else passed++;
    cpu_rst = 1;
    tick();
    cpu_rst = 0;
    total++;
    if ({dbus_req, in_ready, wb_pc_o} !== {1'b0, 1'b1, 32'hBFC0_0000})
      $display("FAIL rst_mid req=%b ready=%b pc=%h exp 0/1/bfc00000", dbus_req, in_ready, wb_pc_o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; mem_wreg_i = 1; mem_wa_i = 5'(i + 1);
      mem_pc_i = 32'h0000_0400 + 32'(i * 4); mem_dreg_i = 32'(i * 3 + 1);
      mem_whilo_i = (i == 2); mem_dhilo_i = 64'h0123_4567_89AB_CDEF;
      mem_cp0_we_i = (i == 3); mem_cp0_waddr_i = 5'd12; mem_cp0_wdata_i = 32'hCAFE_0001;
      tick();
      total++;
      if ({in_ready, wb_valid_o, wb_wreg_o, wb_mreg_o, wb_wa_o} !== {4'b1110, 5'(i + 1)})
        $display("FAIL b2b%0d ready=%b valid=%b wreg=%b mreg=%b wa=%0d exp 1/1/1/0/%0d",
                 i, in_ready, wb_valid_o, wb_wreg_o, wb_mreg_o, wb_wa_o, i + 1);
      else passed++;
      total++;
      if ({wb_pc_o, wb_dreg_o} !== {32'h0000_0400 + 32'(i * 4), 32'(i * 3 + 1)})
        $display("FAIL b2b%0d_data pc=%h dreg=%h exp %h/%h", i, wb_pc_o, wb_dreg_o, 32'h400 + i * 4, i * 3 + 1);
      else passed++;
      if (i == 2) begin
        total++;
        if ({wb_whilo_o, wb_dhilo_o} !== {1'b1, 64'h0123_4567_89AB_CDEF})
          $display("FAIL b2b_hilo whilo=%b dhilo=%h exp 1/0123456789abcdef", wb_whilo_o, wb_dhilo_o);
        else passed++;
      end
      if (i == 3) begin
        total++;
        if ({wb_cp0_we_o, wb_cp0_waddr_o, wb_cp0_wdata_o, wb_whilo_o} !== {1'b1, 5'd12, 32'hCAFE_0001, 1'b0})
          $display("FAIL b2b_cp0 we=%b waddr=%0d wdata=%h whilo=%b exp 1/12/cafe0001/0",
                   wb_cp0_we_o, wb_cp0_waddr_o, wb_cp0_wdata_o, wb_whilo_o);
        else passed++;
      end
    end
    clear_in();
    tick();
    total++;
    if ({wb_valid_o, wb_cp0_we_o} !== 2'b00) $display("FAIL b2b_end valid/cp0_we got %b/%b exp 0/0", wb_valid_o, wb_cp0_we_o);
    else passed++;
  endtask

  initial begin
    cpu_rst = 1;
    clear_in();
    test_reset();
    test_load_word();
    test_store();
    test_misalign();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
